ice51_soc: RTL and testbench

Minimal 8051-subset microcontroller with a UART bootloader, sitting at the top of the ice51 FPGA design between the board pins and the core. After reset it receives exactly 512 code bytes over UART RX into on-chip code RAM. It then releases the core at address 0. The program's writes to SBUF are transmitted on UART TX at 115200 baud, 8N1, from a 12 MHz clock.

---
 rtl/ice51_soc.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_ice51_soc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ice51_soc.sv
// ice51_soc: UART bootloader in front of a small 8051-subset core.
// Optional build macro ICE51_LOAD_ECHO_EN echoes every loaded byte back on TX.
module ice51_soc #(
   parameter int CLKS_PER_BIT = 104,
   parameter int MEM_SIZE     = 512
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_uart_rx,
   output logic o_uart_tx
);
   localparam int AW = $clog2(MEM_SIZE);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_SIZE - 1);
   localparam logic [7:0]    SBUF_ADDR = 8'h99;

   typedef enum logic { MODE_LOAD, MODE_RUN } mode_e;
   typedef enum logic [1:0] { RX_IDLE, RX_START, RX_DATA, RX_STOP } rx_state_e;
   typedef enum logic [1:0] { TX_IDLE, TX_START, TX_DATA, TX_STOP } tx_state_e;
   typedef enum logic [1:0] { C_FETCH, C_OPERAND, C_EXEC } core_state_e;

   // Handshakes: rx_valid_q is a one-cycle strobe with rx_byte_q (the loader
   // always accepts it); tx_launch is taken only in a cycle where tx_busy is low.
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        tx_launch;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        sbuf_launch;
   logic        echo_launch;

   // ---------------- UART receiver ----------------
   logic           rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e      rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_idx_q, rx_idx_d;
   logic [7:0]     rx_shift_q, rx_shift_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // Mid-start re-sample filters glitches shorter than half a bit.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_idx_d   = rx_idx_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  rx_valid_d = 1'b1;
                  rx_byte_d  = rx_shift_q;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // ---------------- Loader, code RAM and core ----------------
   mode_e          mode_q, mode_d;
   logic [AW-1:0]  load_addr_q, load_addr_d;
   core_state_e    core_q, core_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [7:0]     ir_q, ir_d;
   logic [7:0]     op_q, op_d;
   logic [7:0]     a_q, a_d;
   logic           c_q, c_d;
   logic [7:0]     r_q [8];
   logic [7:0]     r_d [8];
   logic [7:0]     rdata_q;
   logic [7:0]     mem [MEM_SIZE];
   logic           mem_we;
   logic [2:0]     rn;
   logic [7:0]     add_src;
   logic [8:0]     add_sum;
   logic [7:0]     r_dec;
   logic [AW-1:0]  rel_target;

   function automatic logic is_two_byte(input logic [7:0] opc);
      casez (opc)
         8'h74, 8'h24, 8'h44, 8'h54, 8'h64, 8'h80, 8'h60, 8'h70, 8'hF5,
         8'b0111_1???, 8'b1101_1???: is_two_byte = 1'b1;
         default:                    is_two_byte = 1'b0;
      endcase
   endfunction

   // The RAM is addressed with pc_d so that rdata_q always holds mem[pc_q].
   always_ff @(posedge i_clk) begin
      if (mem_we) mem[load_addr_q] <= rx_byte_q;
      rdata_q <= mem[pc_d];
   end

   always_comb begin
      mode_d      = mode_q;
      load_addr_d = load_addr_q;
      mem_we      = 1'b0;
      core_d      = core_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      op_d        = op_q;
      a_d         = a_q;
      c_d         = c_q;
      r_d         = r_q;
      sbuf_launch = 1'b0;
      rn          = ir_q[2:0];
      add_src     = ir_q[3] ? r_q[rn] : op_q;
      add_sum     = {1'b0, a_q} + {1'b0, add_src};
      r_dec       = r_q[rn] - 8'd1;
      rel_target  = pc_q + AW'($signed(op_q));

      if (mode_q == MODE_LOAD) begin
         if (rx_valid_q) begin
            mem_we      = 1'b1;
            load_addr_d = load_addr_q + AW'(1);
            if (load_addr_q == ADDR_LAST) begin
               mode_d = MODE_RUN;
               core_d = C_FETCH;
               pc_d   = '0;
            end
         end
      end else begin
         case (core_q)
            C_FETCH: begin
               ir_d   = rdata_q;
               pc_d   = pc_q + AW'(1);
               core_d = is_two_byte(rdata_q) ? C_OPERAND : C_EXEC;
            end
            C_OPERAND: begin
               op_d   = rdata_q;
               pc_d   = pc_q + AW'(1);
               core_d = C_EXEC;
            end
            C_EXEC: begin
               core_d = C_FETCH;
               casez (ir_q)
                  8'h74:        a_d = op_q;
                  8'b0111_1???: r_d[rn] = op_q;
                  8'b1110_1???: a_d = r_q[rn];
                  8'b1111_1???: r_d[rn] = a_q;
                  8'h24, 8'b0010_1???: begin
                     a_d = add_sum[7:0];
                     c_d = add_sum[8];
                  end
                  8'h44:        a_d = a_q | op_q;
                  8'h54:        a_d = a_q & op_q;
                  8'h64:        a_d = a_q ^ op_q;
                  8'h04:        a_d = a_q + 8'd1;
                  8'h14:        a_d = a_q - 8'd1;
                  8'b0000_1???: r_d[rn] = r_q[rn] + 8'd1;
                  8'b0001_1???: r_d[rn] = r_dec;
                  8'h80:        pc_d = rel_target;
                  8'h60:        if (a_q == 8'h00) pc_d = rel_target;
                  8'h70:        if (a_q != 8'h00) pc_d = rel_target;
                  8'b1101_1???: begin
                     r_d[rn] = r_dec;
                     if (r_dec != 8'h00) pc_d = rel_target;
                  end
                  8'hF5: begin
                     // Hold in EXEC until the transmitter frees up; nothing is dropped.
                     if (op_q == SBUF_ADDR) begin
                        if (tx_busy) core_d = C_EXEC;
                        else         sbuf_launch = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            default: core_d = C_FETCH;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q      <= MODE_LOAD;
         load_addr_q <= '0;
         core_q      <= C_FETCH;
         pc_q        <= '0;
         ir_q        <= '0;
         op_q        <= '0;
         a_q         <= '0;
         c_q         <= 1'b0;
         for (int i = 0; i < 8; i++) r_q[i] <= '0;
      end else begin
         mode_q      <= mode_d;
         load_addr_q <= load_addr_d;
         core_q      <= core_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         op_q        <= op_d;
         a_q         <= a_d;
         c_q         <= c_d;
         r_q         <= r_d;
      end
   end

`ifdef ICE51_LOAD_ECHO_EN
   assign echo_launch = (mode_q == MODE_LOAD) && rx_valid_q && !tx_busy;
`else
   assign echo_launch = 1'b0;
`endif

   assign tx_launch = sbuf_launch | echo_launch;
   assign tx_data   = sbuf_launch ? a_q : rx_byte_q;

   // ---------------- UART transmitter ----------------
   tx_state_e      tx_state_q, tx_state_d;
   logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]     tx_idx_q, tx_idx_d;
   logic [7:0]     tx_shift_q, tx_shift_d;
   logic           tx_q, tx_d;

   assign tx_busy   = (tx_state_q != TX_IDLE);
   assign o_uart_tx = tx_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (tx_launch) begin
               tx_state_d = TX_START;
               tx_cnt_d   = '0;
               tx_shift_d = tx_data;
               tx_d       = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_d       = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == BIT_LAST) tx_state_d = TX_IDLE;
            else                      tx_cnt_d   = tx_cnt_q + CW'(1);
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_ice51_soc.sv
// Directed bench for ice51_soc: loads small programs over UART RX and
// checks the bytes the core transmits on UART TX.
module tb_ice51_soc;
   localparam int CPB = 8;
   localparam int MEM = 32;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic tx;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_q [$];
   logic [7:0] prog_q [$];

   ice51_soc #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MEM)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_uart_rx (rx),
      .o_uart_tx (tx)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic check_mode(input string tag, input logic [15:0] want);
      check(tag, 16'(dut.mode_q), want);
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   // Unreachable padding after each program's final SJMP is randomised.
   task automatic load_range(input int first, input int last);
      logic [7:0] b;
      for (int i = first; i <= last; i++) begin
         if (i < prog_q.size()) b = prog_q[i];
         else                   b = 8'($urandom_range(0, 255));
         send_byte(b, 1'b1);
      end
   endtask

   task automatic wait_tx_low(input string tag);
      int t;
      logic timed_out;
      t = 0;
      while (tx !== 1'b0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      timed_out = (t >= 4000);
      check({tag, "_start"}, 16'(timed_out), 16'd0);
   endtask

   task automatic expect_tx(input string tag);
      logic [7:0] got;
      logic [7:0] want;
      logic       stop_bit;
      want = 8'h00;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      wait_tx_low(tag);
      if (tx === 1'b0) begin
         got = '0;
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            got[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         stop_bit = tx;
         check({tag, "_data"}, 16'(got), 16'(want));
         check({tag, "_stop"}, 16'(stop_bit), 16'd1);
      end
   endtask

   task automatic watch_silence(input int n, input string tag);
      int lows;
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check(tag, 16'(lows), 16'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      do_reset();
      check("reset_tx", 16'(tx), 16'd1);
      check_mode("reset_mode", 16'd0);
      check("reset_load_addr", 16'(dut.load_addr_q), 16'd0);

      watch_silence(200, "idle_tx");
      check_mode("idle_mode", 16'd0);

      // Single SBUF write then SJMP to self.
      prog_q = '{8'h74, 8'h41, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      check_mode("p1_mode", 16'd1);
      exp_q.push_back(8'h41);
      expect_tx("p1_b0");
      watch_silence(300, "p1_quiet");

      // ADD with carry-free sum, then a DJNZ loop incrementing A three times.
      do_reset();
      prog_q = '{8'h74, 8'h05, 8'h24, 8'h03, 8'hF5, 8'h99, 8'h78, 8'h03, 8'hE4,
                 8'h74, 8'h00, 8'h04, 8'hD8, 8'hFD, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      exp_q.push_back(8'h08);
      exp_q.push_back(8'h03);
      expect_tx("p2_b0");
      expect_tx("p2_b1");
      watch_silence(300, "p2_quiet");

      // Back-to-back SBUF writes: the second must wait for the first frame.
      do_reset();
      prog_q = '{8'h74, 8'h55, 8'hF5, 8'h99, 8'h74, 8'hAA, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      expect_tx("p3_b0");
      expect_tx("p3_b1");
      watch_silence(300, "p3_quiet");

      // JZ taken with A = 0.
      do_reset();
      prog_q = '{8'h74, 8'h00, 8'h60, 8'h02, 8'h74, 8'hFF, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      exp_q.push_back(8'h00);
      expect_tx("p4a_b0");

      // JZ not taken with A = 1.
      do_reset();
      prog_q = '{8'h74, 8'h01, 8'h60, 8'h02, 8'h74, 8'hFF, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      exp_q.push_back(8'hFF);
      expect_tx("p4b_b0");

      // Framing error during load must not consume a RAM slot.
      do_reset();
      send_byte(8'h5A, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("ferr_load_addr", 16'(dut.load_addr_q), 16'd0);
      prog_q = '{8'h74, 8'h41, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 2);
      check_mode("ferr_still_load", 16'd0);
      check("ferr_addr_last", 16'(dut.load_addr_q), 16'(MEM - 1));
      load_range(MEM - 1, MEM - 1);
      check_mode("ferr_run", 16'd1);
      exp_q.push_back(8'h41);
      expect_tx("ferr_b0");

      // Reset mid-load forces a full reload.
      do_reset();
      for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      check("midload_addr", 16'(dut.load_addr_q), 16'd10);
      do_reset();
      check("midload_addr_rst", 16'(dut.load_addr_q), 16'd0);
      prog_q = '{8'h74, 8'h05, 8'h24, 8'h03, 8'hF5, 8'h99, 8'h78, 8'h03, 8'hE4,
                 8'h74, 8'h00, 8'h04, 8'hD8, 8'hFD, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      exp_q.push_back(8'h08);
      exp_q.push_back(8'h03);
      expect_tx("reload_b0");
      expect_tx("reload_b1");

      // Reset during a TX start bit aborts the frame at the reset edge.
      do_reset();
      prog_q = '{8'h74, 8'h55, 8'hF5, 8'h99, 8'h74, 8'hAA, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      wait_tx_low("abort");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_tx_high", 16'(tx), 16'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_mode("abort_mode", 16'd0);
      watch_silence(150, "abort_quiet");
      prog_q = '{8'h74, 8'h41, 8'hF5, 8'h99, 8'h80, 8'hFE};
      load_range(0, MEM - 1);
      exp_q.push_back(8'h41);
      expect_tx("after_abort_b0");
      watch_silence(200, "after_abort_quiet");

      check("exp_q_drained", 16'(exp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
